// File: rtl/conv_window_ctrl.sv
// Line-buffer sequencer for a KxK convolution window.
// Generates queue push/pop/clear strobes and flags valid windows with their top-left position.
module conv_window_ctrl #(
   parameter int unsigned IMG_W = 28,
   parameter int unsigned IMG_H = 28,
   parameter int unsigned K     = 3,
   parameter int unsigned CW    = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic          pix_vld,
   output logic          pix_rdy,
   output logic          q_push,
   output logic          q_pop,
   output logic          q_clr_n,
   output logic          win_vld,
   output logic [CW-1:0] win_row,
   output logic [CW-1:0] win_col,
   output logic          busy,
   output logic          done
);

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
   localparam logic [CW-1:0] KM1      = CW'(K - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   col_q, col_d;
   logic [CW-1:0]   row_q, row_d;
   logic            win_vld_q, win_vld_d;
   logic [CW-1:0]   win_row_q, win_row_d;
   logic [CW-1:0]   win_col_q, win_col_d;
   logic            clr_n_q, clr_n_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            accept;

   assign pix_rdy = (state_q == RUN);
   assign accept  = pix_vld & pix_rdy;
   // Row 0 only fills the queues; from row 1 on every push is paired with a pop.
   assign q_push  = accept;
   assign q_pop   = accept & (row_q != '0);

   assign q_clr_n = clr_n_q;
   assign win_vld = win_vld_q;
   assign win_row = win_row_q;
   assign win_col = win_col_q;
   assign busy    = busy_q;
   assign done    = done_q;

   // Next-state, counter and registered-output logic.
   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      win_vld_d = 1'b0;
      win_row_d = win_row_q;
      win_col_d = win_col_q;
      clr_n_d   = 1'b1;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = RUN;
               clr_n_d = 1'b0;
               col_d   = '0;
               row_d   = '0;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               clr_n_d = 1'b0;
               col_d   = '0;
               row_d   = '0;
            end else if (accept) begin
               if ((row_q >= KM1) && (col_q >= KM1)) begin
                  win_vld_d = 1'b1;
                  win_row_d = row_q - KM1;
                  win_col_d = col_q - KM1;
               end
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  if (row_q == ROW_LAST) begin
                     row_d   = '0;
                     state_d = DRAIN;
                  end else begin
                     row_d = row_q + CW'(1);
                  end
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         DRAIN: begin
            if (abort) begin
               state_d = IDLE;
               clr_n_d = 1'b0;
               col_d   = '0;
               row_d   = '0;
            end else begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         col_q     <= '0;
         row_q     <= '0;
         win_vld_q <= 1'b0;
         win_row_q <= '0;
         win_col_q <= '0;
         clr_n_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         win_vld_q <= win_vld_d;
         win_row_q <= win_row_d;
         win_col_q <= win_col_d;
         clr_n_q   <= clr_n_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

endmodule
